// File: rtl/ro_sync_seq_pkg.sv
// rtl/ro_sync_seq_pkg.sv - shared types and constants for the register programming sequencer
//
// Purpose: sequencer state encoding, AXI response codes and register stride
// used by ro_sync_cfg_seq. No ports; imported with ro_sync_seq_pkg::*.
package ro_sync_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_FINISH  = 3'd5
  } seq_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte distance between consecutive slave registers.
  localparam int REG_STRIDE = 4;

endpackage

// File: rtl/ro_sync_cfg_seq.sv
// rtl/ro_sync_cfg_seq.sv - AXI4-Lite master that programs and optionally verifies a register block
//
// Purpose: on start, snapshot cfg_data and write word i to BASE_ADDR+4*i for
// every register, one transaction at a time. With RO_SYNC_SEQ_READBACK_EN
// defined, every register is then read back and compared to the snapshot.
// Any bad response (or readback mismatch) stops the sequence and latches
// error/err_idx. Without the macro the readback phase is absent and the
// AR/R channel outputs are tied low.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   start, cfg_data       sequence request and NUM_REGS packed 32-bit words
//   busy, done            sequence active, one-cycle end-of-sequence pulse
//   error, err_idx        sticky failure flag and failing register index
//   M_AXI_AW*/W*/B*       write address, write data, write response channels
//   M_AXI_AR*/R*          read address, read data channels
module ro_sync_cfg_seq
  import ro_sync_seq_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter int BASE_ADDR          = 0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   start,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [3:0]                             err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                             M_AXI_AWPROT,
  output logic                                   M_AXI_AWVALID,
  input  logic                                   M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [3:0]                             M_AXI_WSTRB,
  output logic                                   M_AXI_WVALID,
  input  logic                                   M_AXI_WREADY,
  input  logic [1:0]                             M_AXI_BRESP,
  input  logic                                   M_AXI_BVALID,
  output logic                                   M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                             M_AXI_ARPROT,
  output logic                                   M_AXI_ARVALID,
  input  logic                                   M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                             M_AXI_RRESP,
  input  logic                                   M_AXI_RVALID,
  output logic                                   M_AXI_RREADY
);

  localparam int         DW       = C_M_AXI_DATA_WIDTH;
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

`ifdef RO_SYNC_SEQ_READBACK_EN
  localparam seq_state_t AFTER_WRITES = S_RD_REQ;
`else
  localparam seq_state_t AFTER_WRITES = S_FINISH;
`endif

  seq_state_t                   state, state_nxt;
  logic [NUM_REGS*DW-1:0]       snapshot;
  logic [3:0]                   idx;
  logic                         aw_done, w_done;
  logic [DW-1:0]                snap_word;
  logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr;
  logic                         aw_hs, w_hs, wr_both, last_reg, b_bad;

  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
  // Both halves of the write are complete, counting a handshake happening now.
  assign wr_both  = (aw_done || aw_hs) && (w_done || w_hs);
  assign last_reg = (idx == LAST_IDX);
  assign b_bad    = (M_AXI_BRESP != RESP_OKAY);
  assign reg_addr = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + REG_STRIDE * int'(idx));

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // Select the snapshot word for the current register.
  always_comb begin
    snap_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) snap_word = snapshot[i*DW +: DW];
    end
  end

`ifdef RO_SYNC_SEQ_READBACK_EN
  logic rd_bad;
  assign rd_bad = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != snap_word);
`else
  logic unused_rd;
  assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_WR_REQ;
      S_WR_REQ:  if (wr_both) state_nxt = S_WR_RESP;
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (b_bad)         state_nxt = S_FINISH;
          else if (last_reg) state_nxt = AFTER_WRITES;
          else               state_nxt = S_WR_REQ;
        end
      end
`ifdef RO_SYNC_SEQ_READBACK_EN
      S_RD_REQ:  if (M_AXI_ARREADY) state_nxt = S_RD_RESP;
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          if (rd_bad || last_reg) state_nxt = S_FINISH;
          else                    state_nxt = S_RD_REQ;
        end
      end
`endif
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Sequence datapath: snapshot, register index, per-channel write progress
  // and the sticky error record.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      snapshot <= '0;
      idx      <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      error    <= 1'b0;
      err_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            snapshot <= cfg_data;
            idx      <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
          end
        end
        S_WR_REQ: begin
          if (wr_both) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            if (b_bad) begin
              error   <= 1'b1;
              err_idx <= idx;
            end else if (last_reg) begin
              idx <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
`ifdef RO_SYNC_SEQ_READBACK_EN
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            if (rd_bad) begin
              error   <= 1'b1;
              err_idx <= idx;
            end else if (!last_reg) begin
              idx <= idx + 4'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from state. Payloads are zero outside their request
  // state so the bus is quiet in IDLE and straight after reset.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = 4'h0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      S_WR_REQ: begin
        busy          = 1'b1;
        // Each VALID drops on its own the cycle after its handshake.
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        M_AXI_AWADDR  = reg_addr;
        M_AXI_WDATA   = snap_word;
        M_AXI_WSTRB   = 4'hF;
      end
      S_WR_RESP: begin
        busy         = 1'b1;
        M_AXI_BREADY = 1'b1;
      end
`ifdef RO_SYNC_SEQ_READBACK_EN
      S_RD_REQ: begin
        busy          = 1'b1;
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = reg_addr;
      end
      S_RD_RESP: begin
        busy         = 1'b1;
        M_AXI_RREADY = 1'b1;
      end
`endif
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ro_sync_cfg_seq.sv
// tb/tb_ro_sync_cfg_seq.sv - randomized self-checking bench for ro_sync_cfg_seq
module tb_ro_sync_cfg_seq;
  import ro_sync_seq_pkg::*;

  localparam int AW   = 4;
  localparam int NREG = 4;
`ifdef RO_SYNC_SEQ_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          start;
  logic [127:0]  cfg_data;
  logic          busy, done, error;
  logic [3:0]    err_idx;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0]   M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  ro_sync_cfg_seq #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NREG), .BASE_ADDR(0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs.
  int aw_d, w_d, b_d, r_d, bad_b, bad_r;

  // Observed traffic.
  logic [AW-1:0] aw_q[$];
  logic [31:0]   w_q[$];
  logic [AW-1:0] ar_q[$];
  int            aw_cyc_q[$];
  int            w_cyc_q[$];
  int            b_cnt, r_cnt, done_cnt, proto_viol;
  logic          err_at_done, busy_at_done;
  logic [3:0]    idx_at_done;
  logic [31:0]   mem [NREG];

  // AXI-Lite slave plus bus monitor. Bus is sampled on the falling edge;
  // slave drives its signals 1 time unit after the rising edge.
  initial begin : slave_monitor
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic [AW-1:0] awaddr_s, araddr_s, wr_addr, rd_addr, p_awaddr, p_araddr;
    logic [31:0] wdata_s, wr_data, p_wdata;
    logic got_aw, got_w, b_pend, r_pend, p_aw_stall, p_w_stall, p_ar_stall;
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, aw_cyc, w_cyc, out_w, out_r;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = RESP_OKAY;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = RESP_OKAY;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
    p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0; aw_cyc = 0; w_cyc = 0;
    out_w = 0; out_r = 0;
    forever begin
      @(negedge ACLK);
      aw_hs_s  = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs_s   = M_AXI_WVALID && M_AXI_WREADY;
      b_hs_s   = M_AXI_BVALID && M_AXI_BREADY;
      ar_hs_s  = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs_s   = M_AXI_RVALID && M_AXI_RREADY;
      awaddr_s = M_AXI_AWADDR;
      wdata_s  = M_AXI_WDATA;
      araddr_s = M_AXI_ARADDR;
      if (done) begin
        done_cnt++;
        err_at_done  = error;
        idx_at_done  = err_idx;
        busy_at_done = busy;
      end
      if (ARESET) begin
        out_w = 0; out_r = 0; aw_cyc = 0; w_cyc = 0;
        p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0;
      end else begin
        if (p_aw_stall && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) proto_viol++;
        if (p_w_stall && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata)) proto_viol++;
        if (p_ar_stall && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) proto_viol++;
        if (M_AXI_AWVALID && out_w != 0) proto_viol++;
        if (M_AXI_ARVALID && (out_r != 0 || out_w != 0 || M_AXI_AWVALID || M_AXI_WVALID)) proto_viol++;
        if (M_AXI_AWVALID && (M_AXI_AWPROT != 3'b000)) proto_viol++;
        if (M_AXI_WVALID && (M_AXI_WSTRB != 4'hF)) proto_viol++;
        if (M_AXI_AWVALID) aw_cyc++;
        if (M_AXI_WVALID) w_cyc++;
        if (aw_hs_s) begin aw_q.push_back(awaddr_s); aw_cyc_q.push_back(aw_cyc); aw_cyc = 0; out_w++; end
        if (w_hs_s) begin w_q.push_back(wdata_s); w_cyc_q.push_back(w_cyc); w_cyc = 0; end
        if (b_hs_s) begin b_cnt++; out_w--; end
        if (ar_hs_s) begin ar_q.push_back(araddr_s); out_r++; end
        if (r_hs_s) begin r_cnt++; out_r--; end
        p_aw_stall = M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        p_w_stall  = M_AXI_WVALID && !M_AXI_WREADY;   p_wdata  = M_AXI_WDATA;
        p_ar_stall = M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      end
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = RESP_OKAY;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = RESP_OKAY;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (aw_hs_s) begin got_aw = 1; wr_addr = awaddr_s; end
        if (w_hs_s) begin got_w = 1; wr_data = wdata_s; end
        if (got_aw && got_w) begin
          mem[wr_addr[3:2]] = wr_data;
          got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
        end
        if (b_hs_s) begin M_AXI_BVALID = 0; M_AXI_BRESP = RESP_OKAY; end
        if (b_pend && !M_AXI_BVALID) begin
          if (b_wait >= b_d) begin
            M_AXI_BVALID = 1;
            M_AXI_BRESP  = (int'(wr_addr[3:2]) == bad_b) ? RESP_SLVERR : RESP_OKAY;
            b_pend = 0;
          end else b_wait++;
        end
        if (M_AXI_AWVALID) begin
          if (aw_cnt >= aw_d) M_AXI_AWREADY = 1; else begin M_AXI_AWREADY = 0; aw_cnt++; end
        end else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
        if (M_AXI_WVALID) begin
          if (w_cnt >= w_d) M_AXI_WREADY = 1; else begin M_AXI_WREADY = 0; w_cnt++; end
        end else begin M_AXI_WREADY = 0; w_cnt = 0; end
        if (M_AXI_ARVALID) begin
          if (ar_cnt >= aw_d) M_AXI_ARREADY = 1; else begin M_AXI_ARREADY = 0; ar_cnt++; end
        end else begin M_AXI_ARREADY = 0; ar_cnt = 0; end
        if (ar_hs_s) begin r_pend = 1; rd_addr = araddr_s; r_wait = 0; end
        if (r_hs_s) M_AXI_RVALID = 0;
        if (r_pend && !M_AXI_RVALID) begin
          if (r_wait >= r_d) begin
            M_AXI_RVALID = 1;
            M_AXI_RDATA  = (int'(rd_addr[3:2]) == bad_r) ? 32'h5 : mem[rd_addr[3:2]];
            M_AXI_RRESP  = RESP_OKAY;
            r_pend = 0;
          end else r_wait++;
        end
      end
    end
  end

  task automatic clear_monitor();
    aw_q.delete(); w_q.delete(); ar_q.delete(); aw_cyc_q.delete(); w_cyc_q.delete();
    b_cnt = 0; r_cnt = 0; done_cnt = 0; proto_viol = 0;
    err_at_done = 0; busy_at_done = 0; idx_at_done = 0;
  endtask

  task automatic pulse_start(input logic [127:0] cfg);
    @(posedge ACLK); #1;
    start = 1; cfg_data = cfg;
    @(posedge ACLK); #1;
    start = 0;
  endtask

  // Expected traffic is derived from the transaction rules: write every
  // register in order until a bad BRESP, then (readback builds) read every
  // register until a returned word differs from what was written.
  task automatic run_seq(input logic [127:0] cfg, input int bb, input int br, input int awd,
                         input int wd, input int bd, input int rd, input bit restart);
    logic [AW-1:0] exp_aw[$];
    logic [31:0]   exp_w[$];
    logic [AW-1:0] exp_ar[$];
    logic          exp_err;
    logic [3:0]    exp_idx;
    logic [31:0]   word, seen;
    int            n;
    exp_err = 0; exp_idx = 0;
    for (int i = 0; i < NREG && !exp_err; i++) begin
      word = cfg[32*i +: 32];
      exp_aw.push_back(AW'(4*i));
      exp_w.push_back(word);
      if (i == bb) begin exp_err = 1; exp_idx = 4'(i); end
    end
    if (READBACK && !exp_err) begin
      for (int i = 0; i < NREG && !exp_err; i++) begin
        word = cfg[32*i +: 32];
        seen = (i == br) ? 32'h5 : word;
        exp_ar.push_back(AW'(4*i));
        if (seen != word) begin exp_err = 1; exp_idx = 4'(i); end
      end
    end

    aw_d = awd; w_d = wd; b_d = bd; r_d = rd; bad_b = bb; bad_r = br;
    clear_monitor();
    pulse_start(cfg);
    check_eq("busy_after_start", busy, 1);
    if (restart) begin
      repeat (3) @(posedge ACLK);
      #1;
      start = 1; cfg_data = ~cfg;
      @(posedge ACLK); #1;
      start = 0;
    end
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(posedge ACLK); #1;
      n++;
    end
    repeat (8) @(posedge ACLK);
    #1;
    check_eq("done_count", done_cnt, 1);
    check_eq("busy_at_done", busy_at_done, 0);
    check_eq("error_at_done", err_at_done, exp_err);
    check_eq("err_idx_at_done", idx_at_done, exp_idx);
    check_eq("error_sticky", error, exp_err);
    check_eq("busy_idle", busy, 0);
    check_eq("aw_count", aw_q.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < aw_q.size(); i++)
      check_eq($sformatf("aw_addr[%0d]", i), aw_q[i], exp_aw[i]);
    check_eq("w_count", w_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < w_q.size(); i++)
      check_eq($sformatf("w_data[%0d]", i), w_q[i], exp_w[i]);
    check_eq("b_count", b_cnt, exp_aw.size());
    check_eq("ar_count", ar_q.size(), exp_ar.size());
    for (int i = 0; i < exp_ar.size() && i < ar_q.size(); i++)
      check_eq($sformatf("ar_addr[%0d]", i), ar_q[i], exp_ar[i]);
    check_eq("r_count", r_cnt, exp_ar.size());
    check_eq("protocol_violations", proto_viol, 0);
  endtask

  function automatic logic [63:0] quiet_outputs();
    return {12'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
            busy, done, error, err_idx, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR};
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] cfg;
    int n;
    ARESET = 1; start = 0; cfg_data = '0;
    aw_d = 0; w_d = 0; b_d = 0; r_d = 0; bad_b = -1; bad_r = -1;
    clear_monitor();
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("reset_outputs", quiet_outputs(), 64'd0);
    ARESET = 0;
    repeat (2) @(posedge ACLK);
    #1;

    cfg = {32'd4, 32'd3, 32'd2, 32'd1};
    run_seq(cfg, -1, -1, 0, 0, 0, 0, 0);
    run_seq(cfg, -1, 2, 0, 0, 1, 1, 0);
    run_seq(cfg, 1, -1, 0, 0, 0, 0, 0);

    // Sticky error from the previous run must be cleared by reset.
    check_eq("error_before_reset", error, 1);
    ARESET = 1;
    @(posedge ACLK); #1;
    check_eq("reset_clears_error", {error, err_idx}, 5'd0);
    ARESET = 0;

    run_seq(cfg, -1, -1, 3, 0, 0, 0, 0);
    check_eq("aw_valid_cycles_reg0", (aw_cyc_q.size() > 0) ? aw_cyc_q[0] : 0, 4);
    check_eq("w_valid_cycles_reg0", (w_cyc_q.size() > 0) ? w_cyc_q[0] : 0, 1);

    // Reset in the middle of register 1's write response wait.
    aw_d = 0; w_d = 0; b_d = 6; r_d = 0; bad_b = -1; bad_r = -1;
    clear_monitor();
    pulse_start({32'hA4, 32'hA3, 32'hA2, 32'hA1});
    n = 0;
    while (!(aw_q.size() == 2 && M_AXI_BREADY) && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_eq("reached_wr_resp_reg1", (n < 200), 1);
    ARESET = 1;
    @(posedge ACLK); #1;
    check_eq("mid_seq_reset_outputs", quiet_outputs(), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 0;
    repeat (10) @(posedge ACLK);
    #1;
    check_eq("no_done_after_abort", done_cnt, 0);
    run_seq({32'hB4, 32'hB3, 32'hB2, 32'hB1}, -1, -1, 1, 2, 0, 0, 0);

    run_seq(cfg, -1, -1, 0, 0, 0, 0, 1);

    for (int t = 0; t < 10; t++) begin
      cfg = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NREG; i++)
        if (cfg[32*i +: 32] == 32'h5) cfg[32*i +: 32] = 32'h105;
      run_seq(cfg,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NREG-1)) : -1,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NREG-1)) : -1,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_sync_cfg_seq.md
RO_SYNC_CFG_SEQ -- requirements
Module: ro_sync_cfg_seq

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, the AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, the register width; only 32 is legal.
REQ-003 SHALL have parameter NUM_REGS, default 4, the number of slave registers to program, range 1..16.
REQ-004 SHALL have parameter BASE_ADDR, default 0, the address of register 0.
REQ-005 SHALL have port ACLK, input, width 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port ARESET, input, width 1, a synchronous, active-high reset.
REQ-007 SHALL have port start, input, width 1, a single-cycle request to begin a programming sequence.
REQ-008 SHALL have port cfg_data, input, width NUM_REGS*32, holding the register values; word i is bits [32i+31:32i].
REQ-009 SHALL have port busy, output, width 1, high while a sequence is in progress.
REQ-010 SHALL have port done, output, width 1, a one-cycle pulse when a sequence ends.
REQ-011 SHALL have port error, output, width 1, a sticky failure flag.
REQ-012 SHALL have port err_idx, output, width 4, the register index that failed.
REQ-013 SHALL have the AW channel as master outputs M_AXI_AWADDR (C_M_AXI_ADDR_WIDTH), M_AXI_AWPROT (3), M_AXI_AWVALID (1) and input M_AXI_AWREADY (1).
REQ-014 SHALL have the W channel as master outputs M_AXI_WDATA (32), M_AXI_WSTRB (4), M_AXI_WVALID (1) and input M_AXI_WREADY (1).
REQ-015 SHALL have the B channel as inputs M_AXI_BRESP (2), M_AXI_BVALID (1) and output M_AXI_BREADY (1).
REQ-016 SHALL have the AR channel as master outputs M_AXI_ARADDR, M_AXI_ARPROT (3), M_AXI_ARVALID and input M_AXI_ARREADY.
REQ-017 SHALL have the R channel as inputs M_AXI_RDATA (32), M_AXI_RRESP (2), M_AXI_RVALID and output M_AXI_RREADY.

Function
REQ-018 SHALL implement the state machine IDLE -> WR_REQ -> WR_RESP -> (next register or RD_REQ) -> RD_RESP -> (next register or FINISH) -> IDLE.
REQ-019 SHALL, on start in IDLE, snapshot cfg_data, clear error and err_idx, set idx=0 and busy=1, and move to WR_REQ on the next cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL, in WR_REQ, assert AWVALID and WVALID together with AWADDR=BASE_ADDR+4*idx, WDATA=snapshot[idx], WSTRB=4'hF and PROT=3'b000.
REQ-022 SHALL drop each of AWVALID and WVALID independently in the cycle after its handshake, and enter WR_RESP once both have completed, including when both complete in the same cycle.
REQ-023 SHALL hold BREADY high in WR_RESP; on BVALID with BRESP=OKAY it either increments idx and returns to WR_REQ, or, when idx=NUM_REGS-1, resets idx to 0 and moves to RD_REQ.
REQ-024 SHALL, in RD_REQ, hold ARVALID with ARADDR=BASE_ADDR+4*idx until ARREADY, then move to RD_RESP.
REQ-025 SHALL hold RREADY high in RD_RESP; a beat with RVALID, RRESP=OKAY and RDATA equal to snapshot[idx] advances to the next register, or to FINISH after the last one.
REQ-026 SHALL, on a non-OKAY BRESP or RRESP or on a data mismatch, set error=1 and err_idx=idx and go directly to FINISH, with no further transactions.
REQ-027 SHALL, in FINISH, pulse done for exactly one cycle, clear busy in the same cycle, and return to IDLE.
REQ-028 SHALL never have more than one outstanding transaction, and SHALL never change any VALID-qualified payload while VALID is high and READY is low.

Reset
REQ-029 SHALL, on ARESET=1 at a clock edge, return to IDLE and drive all VALID, READY, busy, done, error and err_idx low and all address and data outputs to 0, including in the middle of a sequence; no done pulse is produced for the aborted sequence.

Configuration
REQ-030 SHALL, when macro RO_SYNC_SEQ_READBACK_EN is defined, include the RD_REQ/RD_RESP readback-and-compare phase.
REQ-031 SHALL, when RO_SYNC_SEQ_READBACK_EN is undefined, go from the last WR_RESP directly to FINISH, tie ARVALID and RREADY to 0, and flag errors only on BRESP.

Structure
REQ-032 SHALL place the state enum, the AXI response constants (OKAY=2'b00, SLVERR=2'b10) and the register stride constant (4) in the package ro_sync_seq_pkg.
REQ-033 SHALL be a single module with no sub-module; the channel logic is simple enough to sit inside one FSM.

Verification
REQ-034 SHALL cover, with READBACK_EN, cfg_data={4,3,2,1} and start: four writes to 0x0, 0x4, 0x8 and 0xC carrying 1..4, then four reads matching, then one done pulse with error=0.
REQ-035 SHALL cover a slave returning RDATA=0x5 for register 2: error=1, err_idx=2, done pulses, and no read is issued to 0xC.
REQ-036 SHALL cover BRESP=SLVERR on register 1: error=1, err_idx=1, no further AW is issued, and done pulses.
REQ-037 SHALL cover AWREADY delayed 3 cycles while WREADY arrives immediately: WVALID drops after 1 cycle, AWVALID is held stable for 3 cycles, and exactly one B is accepted.
REQ-038 SHALL cover ARESET asserted during WR_RESP of register 1: all outputs are 0 the next cycle, there is no done pulse, and a later start restarts at 0x0.
REQ-039 SHALL cover start pulsed while busy: it is ignored, exactly one sequence runs and exactly one done pulse is produced.
